// File: rtl/hub75_scan_ctrl_if.sv
// HUB75 scan bus: frame-buffer read port plus panel drive pins.
// master: scan controller (rd_en/rd_addr/panel pins out, rd_data in).
interface hub75_scan_ctrl_if #(
  parameter int NUM_COLS = 64,
  parameter int NUM_ROWS = 32
);
  localparam int RB = $clog2(NUM_ROWS / 2);
  localparam int CB = $clog2(NUM_COLS);

  logic          rd_en;
  logic [RB+CB-1:0] rd_addr;
  logic [5:0]    rd_data;
  logic          bclk;
  logic [2:0]    rgb_top;
  logic [2:0]    rgb_bot;
  logic [RB-1:0] addr;
  logic          le;
  logic          oe;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output bclk, rgb_top, rgb_bot,
    output addr, le, oe
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  bclk, rgb_top, rgb_bot,
    input  addr, le, oe
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row-scan controller: fetch pixel pairs, shift, latch, display.
// Ports: clk, n_reset, enable, [brightness], bus (master), busy, frame_done.
// Optional: HUB75_BRIGHTNESS_EN adds brightness[7:0] to scale DISPLAY.
module hub75_scan_ctrl #(
  parameter int NUM_COLS     = 64,
  parameter int NUM_ROWS     = 32,
  parameter int BCLK_DIV     = 2,
  parameter int LATCH_CYCLES = 2,
  parameter int ON_CYCLES    = 64
) (
  input  logic clk,
  input  logic n_reset,
  input  logic enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0] brightness,
`endif
  hub75_scan_ctrl_if.master bus,
  output logic busy,
  output logic frame_done
);
  localparam int RB = $clog2(NUM_ROWS / 2);
  localparam int CB = $clog2(NUM_COLS);
  localparam logic [RB-1:0] ROW_LAST = RB'(NUM_ROWS / 2 - 1);
  localparam logic [CB-1:0] COL_LAST = CB'(NUM_COLS - 1);
  localparam logic [CB-1:0] COL_PEN  = CB'(NUM_COLS - 2);
  localparam logic [15:0]   DIV_M1   = 16'(BCLK_DIV - 1);
  localparam logic [15:0]   LAT_M1   = 16'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, PREFETCH, SHIFT, LATCH, DISPLAY
  } state_t;

  state_t        state;
  logic [RB-1:0] row;
  logic [CB-1:0] col;
  logic [15:0]   cnt;
  logic [15:0]   on_len;
  logic [15:0]   on_nx;
  logic [5:0]    pix;
  logic          load;
  logic          row_end;

`ifdef HUB75_BRIGHTNESS_EN
  logic [15:0] prod;
  assign prod  = 16'(ON_CYCLES) * {8'd0, brightness};
  assign on_nx = prod >> 8;
`else
  assign on_nx = 16'(ON_CYCLES);
`endif

  // rd_data arrives in the first low cycle; pass it straight through
  // so rgb is valid for the whole low phase before the rising edge.
  assign load = (state == SHIFT) && !bus.bclk
              && (cnt == 16'd0);
  assign bus.rgb_top = load ? bus.rd_data[2:0] : pix[2:0];
  assign bus.rgb_bot = load ? bus.rd_data[5:3] : pix[5:3];

  // A zero display length ends the row straight out of LATCH.
  assign row_end =
      ((state == DISPLAY) && (cnt == on_len - 16'd1))
    || ((state == LATCH) && (cnt == LAT_M1)
        && (on_len == 16'd0));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      cnt         <= '0;
      on_len      <= '0;
      pix         <= '0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.bclk    <= 1'b0;
      bus.addr    <= '0;
      bus.le      <= 1'b0;
      bus.oe      <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      bus.rd_en  <= 1'b0;
      frame_done <= 1'b0;
      if (load) pix <= bus.rd_data;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state       <= PREFETCH;
            row         <= '0;
            busy        <= 1'b1;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= '0;
          end
        end
        PREFETCH: begin
          state       <= SHIFT;
          cnt         <= '0;
          col         <= '0;
          bus.rd_en   <= (NUM_COLS > 1);
          bus.rd_addr <= {row, CB'(1)};
        end
        SHIFT: begin
          cnt <= cnt + 16'd1;
          if (cnt == DIV_M1) begin
            cnt <= '0;
            if (!bus.bclk) begin
              bus.bclk <= 1'b1;
            end else begin
              bus.bclk <= 1'b0;
              if (col == COL_LAST) begin
                state    <= LATCH;
                bus.le   <= 1'b1;
                bus.addr <= row;
                on_len   <= on_nx;
              end else begin
                col         <= col + CB'(1);
                bus.rd_en   <= (col != COL_PEN);
                bus.rd_addr <= {row, col + CB'(2)};
              end
            end
          end
        end
        LATCH: begin
          cnt <= cnt + 16'd1;
          if (cnt == LAT_M1) begin
            cnt    <= '0;
            bus.le <= 1'b0;
            if (on_len != 16'd0) begin
              state  <= DISPLAY;
              bus.oe <= 1'b0;
            end
          end
        end
        DISPLAY: begin
          cnt <= cnt + 16'd1;
          if (cnt == on_len - 16'd1) begin
            cnt    <= '0;
            bus.oe <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (row_end) begin
        if (row != ROW_LAST) begin
          row         <= row + RB'(1);
          state       <= PREFETCH;
          bus.rd_en   <= 1'b1;
          bus.rd_addr <= {row + RB'(1), CB'(0)};
        end else begin
          row        <= '0;
          frame_done <= 1'b1;
          if (enable) begin
            state       <= PREFETCH;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= '0;
          end else begin
            state       <= IDLE;
            busy        <= 1'b0;
            bus.addr    <= '0;
            bus.rd_addr <= '0;
            pix         <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: panel model, row scoreboard, timing.
// Second instance covers BCLK_DIV=1, NUM_COLS=32.
`timescale 1ns/1ps
module tb_hub75_scan_ctrl;
`ifdef HUB75_BRIGHTNESS_EN
  localparam int MAIN_ON = 63;
  localparam int DUT2_ON = 63;
`else
  localparam int MAIN_ON = 64;
  localparam int DUT2_ON = 64;
`endif
  localparam int ROW_LEN = 1 + 256 + 2 + MAIN_ON;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_reset, enable, busy, frame_done;
  logic n_reset2, enable2, busy2, frame_done2;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] brightness, brightness2;
`endif

  hub75_scan_ctrl_if #(.NUM_COLS(64), .NUM_ROWS(32)) bus ();
  hub75_scan_ctrl_if #(.NUM_COLS(32), .NUM_ROWS(32)) bus2 ();

  hub75_scan_ctrl dut (
    .clk(clk), .n_reset(n_reset), .enable(enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .bus(bus), .busy(busy), .frame_done(frame_done)
  );

  hub75_scan_ctrl #(.NUM_COLS(32), .BCLK_DIV(1)) dut2 (
    .clk(clk), .n_reset(n_reset2), .enable(enable2),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness2),
`endif
    .bus(bus2), .busy(busy2), .frame_done(frame_done2)
  );

  // frame buffers: one-cycle read latency
  always @(posedge clk) begin
    if (bus.rd_en)
      bus.rd_data <= {2{bus.rd_addr[8:6] ^ bus.rd_addr[2:0]}};
    if (bus2.rd_en)
      bus2.rd_data <= bus2.rd_addr[5:0];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [191:0] obs,
                     input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   a;
    logic [191:0] top;
    logic [191:0] bot;
  } row_t;
  row_t sbq[$];

  function automatic logic [191:0] exp_bits(input int r);
    logic [191:0] v = '0;
    for (int c = 0; c < 64; c++) v[3*(63-c) +: 3] = 3'(r ^ c);
    return v;
  endfunction

  task automatic push_rows(input int n);
    for (int r = 0; r < n; r++) begin
      row_t e;
      e.a = 4'(r);
      e.top = exp_bits(r);
      e.bot = exp_bits(r);
      sbq.push_back(e);
    end
  endtask

  // panel model on the main instance, sampled at negedge
  logic [191:0] sr_top = '0, sr_bot = '0;
  int edges = 0, hi_run = 0, lo_run = 0, last_rise = 0;
  int oe_run = 0, phase_bad = 0, fd_count = 0;
  int exp_on = MAIN_ON;
  logic bclk_q = 1'b0, le_q = 1'b0, oe_q = 1'b1;
  logic leoe_bad = 1'b0;
  bit sb_on = 1'b1;
  row_t mon_e;

  always @(negedge clk) begin
    if (!n_reset) begin
      edges = 0; hi_run = 0; lo_run = 0; oe_run = 0;
      phase_bad = 0; sr_top = '0; sr_bot = '0;
      bclk_q = 1'b0; le_q = 1'b0; oe_q = 1'b1;
    end else begin
      if (bus.le && !bus.oe) leoe_bad = 1'b1;
      if (frame_done) fd_count++;
      if (bus.bclk && !bclk_q) begin
        if (edges > 0 && lo_run != 2) phase_bad++;
        sr_top = {sr_top[188:0], bus.rgb_top};
        sr_bot = {sr_bot[188:0], bus.rgb_bot};
        edges++;
        last_rise = cyc;
        hi_run = 1;
      end else if (bus.bclk) hi_run++;
      if (!bus.bclk && bclk_q) begin
        if (hi_run != 2) phase_bad++;
        lo_run = 1;
      end else if (!bus.bclk) lo_run++;
      if (bus.le && !le_q) begin
        chk("row_edges", edges, 64);
        chk("le_gap", cyc - last_rise, 2);
        chk("phase_len", phase_bad, 0);
        if (sb_on) begin
          chk("sb_row_expected", sbq.size() > 0, 1);
          if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("row_addr", bus.addr, mon_e.a);
            chk("row_top", sr_top, mon_e.top);
            chk("row_bot", sr_bot, mon_e.bot);
          end
        end
        edges = 0;
        phase_bad = 0;
      end
      if (!bus.oe) oe_run++;
      if (bus.oe && !oe_q) begin
        chk("oe_low_len", oe_run, exp_on);
        oe_run = 0;
      end
      bclk_q = bus.bclk;
      le_q = bus.le;
      oe_q = bus.oe;
    end
  end

  function automatic logic [25:0] outs();
    return {bus.bclk, bus.rgb_top, bus.rgb_bot, bus.addr,
            bus.le, bus.oe, bus.rd_en, bus.rd_addr,
            busy, frame_done};
  endfunction

  localparam logic [25:0] RST_OUTS =
    {1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0};

  int t0, n, e2, rows2, t_le, lowc, les;
  logic pb, pl, po;

  task automatic wait_busy();
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 6000 && !frame_done; i++) @(negedge clk);
  endtask

  initial begin
    n_reset = 0; enable = 0; n_reset2 = 0; enable2 = 0;
`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd255; brightness2 = 8'd255;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), RST_OUTS);

    // frame 0: full readout and frame length
    n_reset = 1;
    @(negedge clk);
    chk("idle_outs", outs(), RST_OUTS);
    push_rows(16);
    enable = 1;
    wait_busy();
    chk("start_busy", busy, 1);
    chk("prefetch", {bus.rd_en, bus.rd_addr}, {1'b1, 10'd0});
    t0 = cyc;
    wait_fd();
    chk("frame_done_seen", frame_done, 1);
    chk("frame_len", cyc - t0, 16 * ROW_LEN);
    push_rows(16);
    @(negedge clk);
    chk("fd_count0", fd_count, 1);
    chk("fd_width", frame_done, 0);

    // frame 1: drop enable at row 5, frame still completes
    for (int i = 0; i < 3000 && bus.addr != 4'd5; i++)
      @(negedge clk);
    chk("reach_row5", bus.addr, 5);
    enable = 0;
    wait_fd();
    chk("frame1_done", frame_done, 1);
    chk("stop_busy", busy, 0);
    chk("stop_oe", bus.oe, 1);
    @(negedge clk);
    chk("fd_count1", fd_count, 2);
    chk("sb_drained1", sbq.size(), 0);
    repeat (10) @(negedge clk);
    chk("stays_idle", outs(), RST_OUTS);

    // async reset at row 7, column 30
    push_rows(7);
    enable = 1;
    for (int i = 0; i < 6000 &&
         !(bus.rd_en && bus.rd_addr == 10'(7*64+31)); i++)
      @(negedge clk);
    chk("reach_r7c30", {bus.rd_en, bus.rd_addr}, {1'b1, 10'(7*64+31)});
    #1 n_reset = 0;
    #1 chk("async_reset", outs(), RST_OUTS);
    repeat (2) @(negedge clk);
    chk("sb_drained2", sbq.size(), 0);
    push_rows(16);
    n_reset = 1;
    wait_busy();
    chk("restart_addr", {bus.rd_en, bus.rd_addr}, {1'b1, 10'd0});
    repeat (5) @(negedge clk);
    enable = 0;
    wait_fd();
    chk("restart_done", {frame_done, busy}, 2'b10);
    @(negedge clk);
    chk("sb_drained3", sbq.size(), 0);

    // second instance: BCLK_DIV=1, NUM_COLS=32
    n_reset2 = 1; enable2 = 1;
    e2 = 0; rows2 = 0; t_le = 0; pb = 0; pl = 0;
    for (int i = 0; i < 400 && rows2 < 2; i++) begin
      @(negedge clk);
      if (bus2.bclk && !pb) e2++;
      if (bus2.le && !pl) begin
        chk("dut2_edges", e2, 32);
        if (rows2 == 1)
          chk("dut2_period", cyc - t_le, 1 + 64 + 2 + DUT2_ON);
        e2 = 0; t_le = cyc; rows2++;
      end
      pb = bus2.bclk; pl = bus2.le;
    end
    chk("dut2_rows", rows2, 2);
    enable2 = 0;

`ifdef HUB75_BRIGHTNESS_EN
    sb_on = 0;
    n_reset = 0; brightness = 8'd128; exp_on = 32;
    @(negedge clk);
    n_reset = 1; enable = 1;
    repeat (700) @(negedge clk);
    n_reset = 0; brightness = 8'd0;
    @(negedge clk);
    n_reset = 1;
    lowc = 0; les = 0; t_le = 0; pl = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (!bus.oe) lowc++;
      if (bus.le && !pl) begin
        if (les == 1) chk("b0_period", cyc - t_le, 259);
        t_le = cyc; les++;
      end
      pl = bus.le;
    end
    chk("b0_oe_never_low", lowc, 0);
    n_reset = 0; brightness = 8'd255; exp_on = 63;
    @(negedge clk);
    n_reset = 1;
    repeat (700) @(negedge clk);
    enable = 0; n_reset = 0;
    @(negedge clk);
    n_reset = 1;
`endif

    chk("le_oe_overlap", leoe_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Row-scan controller for the 64x32 HUB75 LED panel. Runs in the system clock domain.
- Fetches pixel pairs from the frame-buffer read port and generates bclk, rgb_top/rgb_bot, addr, le and oe for the panel.
- Scans all NUM_ROWS/2 row pairs per frame, continuously while enabled. Signals each completed frame to the frame-buffer writer.

Parameters:
- NUM_COLS, 64, columns per row; bclk rising edges per row.
- NUM_ROWS, 32, panel rows; NUM_ROWS/2 row pairs are scanned, so addr width = $clog2(NUM_ROWS/2).
- BCLK_DIV, 2, clk cycles per bclk half-period; must be >= 1.
- LATCH_CYCLES, 2, clk cycles le is held high; must be >= 1.
- ON_CYCLES, 64, clk cycles oe is held low per row; must be >= 1.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- enable  in  1  run scanning; sampled at frame boundaries
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  $clog2(NUM_ROWS/2)+$clog2(NUM_COLS)  {row, col}
- rd_data  in  6  [2:0] top-half {b,g,r}, [5:3] bottom-half {b,g,r}; valid 1 cycle after rd_en
- bclk  out  1  panel shift clock
- rgb_top  out  3  {b,g,r} for row r
- rgb_bot  out  3  {b,g,r} for row r+NUM_ROWS/2
- addr  out  4  row-pair select
- le  out  1  latch enable, active high
- oe  out  1  output enable, active low (1 = blanked)
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last row's DISPLAY phase
- Clock and reset are one clock, clk, with asynchronous active-low reset n_reset.

Behaviour:
- Reset values (async, immediate): bclk=0, rgb_top=0, rgb_bot=0, addr=0, le=0, oe=1, rd_en=0, rd_addr=0, busy=0, frame_done=0, FSM=IDLE, row=0, col=0.
- States: IDLE, PREFETCH, SHIFT, LATCH, DISPLAY.
- IDLE: outputs at reset values. If enable=1, go to PREFETCH with row=0.
- PREFETCH (1 cycle):
  - rd_en=1, rd_addr={row,0}.
  - Then SHIFT.
- SHIFT, per column c = 0..NUM_COLS-1:
  - Low phase (BCLK_DIV cycles, bclk=0): rgb_top/rgb_bot load from rd_data on the first cycle. rd_en pulses for column c+1 in the same cycle (no read after the last column).
  - High phase (BCLK_DIV cycles, bclk=1).
  - After exactly NUM_COLS rising edges, drive bclk=0 and go to LATCH.
  - Column 0 is shifted first, so it ends in panel bit NUM_COLS-1.
  - oe=1 throughout SHIFT.
- LATCH (LATCH_CYCLES cycles):
  - addr=row on entry, held until the next LATCH.
  - le=1, oe=1, bclk=0.
- DISPLAY (ON_CYCLES cycles):
  - oe=0, le=0.
  - On exit, oe=1. If row < NUM_ROWS/2-1: row++ and go to PREFETCH.
  - Otherwise: frame_done=1 for one cycle and row wraps to 0. Then PREFETCH if enable=1, else IDLE.
- Timing with defaults:
  - SHIFT = 2*BCLK_DIV*NUM_COLS = 256 cycles.
  - Row period = 1+256+2+64 = 323 cycles.
  - Frame = 16*323 = 5168 cycles.
- enable deasserted mid-frame: the current frame completes, including frame_done. No truncation.
- rgb is stable at least BCLK_DIV cycles before and after every bclk rising edge.
- le and oe=0 are never asserted together. bclk never toggles outside SHIFT.
- Reset mid-operation: immediate return to reset values; the next frame restarts at row 0.
- Counters (col, row, phase) wrap only under FSM control. No rollover into illegal values.

Optional Feature:
- HUB75_BRIGHTNESS_EN defined:
  - Adds input port brightness[7:0].
  - DISPLAY length = ON_CYCLES*brightness/256 cycles, computed in 16-bit arithmetic and truncated.
  - brightness=0 skips DISPLAY entirely; oe stays 1 and the FSM goes LATCH -> next row.
  - brightness is sampled at LATCH entry.
- Undefined: no brightness port; DISPLAY is fixed at ON_CYCLES.

Test Plan:
- Frame readout: reset, enable=1, frame buffer filled with pattern rd_data = row[2:0]^col[2:0] on both halves. Required:
  - Panel model receives 16 rows, each exactly 64 bits.
  - Row r bit 63 equals pattern at column 0.
  - addr sequence 0..15.
  - frame_done pulses once, 5168 cycles after leaving IDLE.
- Phase timing: defaults. Required:
  - bclk high/low phases are exactly 2 cycles each.
  - le is high 2 cycles after the 64th rising edge.
  - oe is low exactly 64 cycles.
  - le&~oe is never true.
- Stop at boundary: deassert enable at row 5 of frame 1. Required: frame completes to row 15, frame_done pulses, FSM enters IDLE, busy=0, oe=1.
- Async reset mid-SHIFT: pulse n_reset low at column 30 of row 7. Required:
  - All outputs are at reset values in the same cycle.
  - After release with enable=1, scanning restarts at addr 0, column 0.
- Parameter sweep: BCLK_DIV=1, NUM_COLS=32. Required: 32 bclk edges per row and row period 1+64+2+64 = 131 cycles.
- HUB75_BRIGHTNESS_EN:
  - brightness=128 -> oe low for 32 cycles.
  - brightness=0 -> oe never low, row period 259 cycles.
  - brightness=255 -> oe low for 63 cycles.
